// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the tiny-core register file with bypass and busy scoreboard.
package reg_file_sb_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int NREG       = 1 << DEF_ADDR_W;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/issue and writeback bundle of the register file; master drives requests, slave is the file.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              rd1_rdy;
    logic              rd2_rdy;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_ok;
    logic              flush;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, iss_valid, iss_addr, flush,
        input  rd1_data, rd2_data, rd1_rdy, rd2_rdy, iss_ok, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd1_addr, rd2_addr, iss_valid, iss_addr, flush,
        output rd1_data, rd2_data, rd1_rdy, rd2_rdy, iss_ok, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits and their registered population count.
module reg_file_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG_P = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [NREG_P-1:0] busy,
    output logic [ADDR_W:0]   busy_cnt
);
    logic [NREG_P-1:0] busy_r;
    logic [NREG_P-1:0] busy_nxt_s;
    logic [ADDR_W:0]   cnt_r;

    function automatic logic [ADDR_W:0] popcount(input logic [NREG_P-1:0] v);
        logic [ADDR_W:0] c;
        c = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREG_P; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next busy vector: flush beats a new producer, which beats a writeback clear.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREG_P; i++) begin
            if (flush) begin
                busy_nxt_s[i] = 1'b0;
            end else if (set_en && (set_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (clr_en && (clr_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy state and its count advance together so the count never lags the bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREG_P{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= popcount(busy_nxt_s);
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one write port, optional write-to-read bypass
// and a busy scoreboard telling issue logic when operands and destinations are free.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int NR = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] regs_r [NR];
    logic [NR-1:0]     busy_s;
    logic              wr_act_s;
    logic              byp1_s;
    logic              byp2_s;
    logic              iss_ok_s;
    logic              set_en_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    assign wr_act_s = bus.wr_en && (bus.wr_addr != ZERO_ADDR);

    // Storage; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_act_s) begin
            regs_r[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read muxes with forwarding of the in-flight writeback value.
    always_comb begin
        byp1_s = (BYPASS != 32'sd0) && bus.wr_en && (bus.wr_addr == bus.rd1_addr);
        byp2_s = (BYPASS != 32'sd0) && bus.wr_en && (bus.wr_addr == bus.rd2_addr);
        if (bus.rd1_addr == ZERO_ADDR) begin
            rd1_s = {DATA_W{1'b0}};
        end else if (byp1_s) begin
            rd1_s = bus.wr_data;
        end else begin
            rd1_s = regs_r[bus.rd1_addr];
        end
        if (bus.rd2_addr == ZERO_ADDR) begin
            rd2_s = {DATA_W{1'b0}};
        end else if (byp2_s) begin
            rd2_s = bus.wr_data;
        end else begin
            rd2_s = regs_r[bus.rd2_addr];
        end
    end

    // A destination still owned by an earlier producer stalls issue (WAW).
    assign iss_ok_s = !bus.flush && ((bus.iss_addr == ZERO_ADDR) || !busy_s[bus.iss_addr]);
    assign set_en_s = bus.iss_valid && iss_ok_s && (bus.iss_addr != ZERO_ADDR);

    reg_file_scoreboard #(.ADDR_W(ADDR_W), .NREG_P(NR)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .set_en   (set_en_s),
        .set_addr (bus.iss_addr),
        .clr_en   (wr_act_s),
        .clr_addr (bus.wr_addr),
        .busy     (busy_s),
        .busy_cnt (bus.busy_cnt)
    );

    assign bus.rd1_data = rd1_s;
    assign bus.rd2_data = rd2_s;
    assign bus.rd1_rdy  = !busy_s[bus.rd1_addr] || byp1_s;
    assign bus.rd2_rdy  = !busy_s[bus.rd2_addr] || byp2_s;
    assign bus.iss_ok   = iss_ok_s;
endmodule
